// File: rtl/run_ctrl.sv
// run_ctrl: debounced continuous/single-step run controller for CPU debug
module run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cont,
  input  logic        step,
  output logic        run,
  output logic        paused,
  output logic        cont_db,
  output logic        step_db,
  output logic [15:0] step_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {PAUSE, STEP, HOLD, RUN} state_t;
  state_t state, nxt;
  logic [1:0] raw, db;
  logic [SYNC_STAGES-1:0] sync [2];
  logic [CW-1:0] cnt [2];
  logic step_prev;
  assign raw = {step, cont};
  assign cont_db = db[0];
  assign step_db = db[1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      db <= '0;
      for (int i = 0; i < 2; i++) begin
        sync[i] <= '0;
        cnt[i] <= '0;
      end
    end else
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
        if (sync[i][SYNC_STAGES-1] == db[i])
          cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i] <= sync[i][SYNC_STAGES-1];
          cnt[i] <= '0;
        end else
          cnt[i] <= cnt[i] + 1'b1;
      end
  always_comb begin
    nxt = state;
    case (state)
      PAUSE: nxt = cont_db ? RUN : (step_db && !step_prev) ? STEP : PAUSE;
      STEP:  nxt = cont_db ? RUN : HOLD;
      HOLD:  nxt = cont_db ? RUN : !step_db ? PAUSE : HOLD;
      RUN:   nxt = cont_db ? RUN : PAUSE;
      default: nxt = PAUSE;
    endcase
  end
  // outputs are registered from the next state so they track the state register exactly
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= PAUSE;
      run <= 1'b0;
      paused <= 1'b1;
      step_cnt <= '0;
      step_prev <= 1'b0;
    end else begin
      state <= nxt;
      run <= nxt == STEP || nxt == RUN;
      paused <= nxt != RUN;
      step_cnt <= step_cnt + 16'(nxt == STEP);
      step_prev <= step_db;
    end
endmodule
